// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache. It serves hits in the
// request cycle and freezes the pipeline while it does a line write-back and refill.
module dcache_controller #(
  parameter int NUM_SETS  = 16,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_write_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - 5 - IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    GAP,
    ALLOCATE,
    REFILL
  } state_t;

  state_t                state_q;
  logic [NUM_SETS-1:0]   valid_q;
  logic [NUM_SETS-1:0]   dirty_q;
  logic [LINE_BITS-1:0]  line_q;
  logic [TAG_W-1:0]      tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0]  data_q [NUM_SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       word;
  logic             hit;
  logic             store_hit;
  logic             unused_addr_bits;

  assign idx  = cpu_addr_i[5 +: IDX_W];
  assign tag  = cpu_addr_i[31 -: TAG_W];
  assign word = cpu_addr_i[4:2];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit       = valid_q[idx] & (tag_q[idx] == tag);
  assign store_hit = (state_q == IDLE) & cpu_req_i & cpu_write_i & hit;

  assign cpu_data_o   = data_q[idx][{word, 5'b0} +: 32];
  assign cpu_stall_o  = (state_q != IDLE) | (cpu_req_i & ~hit);
  assign mem_enable_o = (state_q == WRITEBACK) | (state_q == ALLOCATE);
  assign mem_write_o  = (state_q == WRITEBACK);
  assign mem_data_o   = data_q[idx];
  // The victim address comes from the stored tag; a refill uses the request address.
  assign mem_addr_o   = (state_q == WRITEBACK) ? {tag_q[idx], idx, 5'b0}
                                               : {cpu_addr_i[31:5], 5'b0};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      line_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req_i && !hit) begin
            state_q <= (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
          end
          if (store_hit) begin
            dirty_q[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) state_q <= GAP;
        end
        GAP: begin
          state_q <= ALLOCATE;
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            line_q  <= mem_data_i;
            state_q <= REFILL;
          end
        end
        REFILL: begin
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (state_q == REFILL) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= line_q;
    end else if (store_hit) begin
      data_q[idx][{word, 5'b0} +: 32] <= cpu_data_i;
    end
  end

endmodule
